// File: rtl/flash_therm_enc_pipe_if.sv
// rtl/flash_therm_enc_pipe_if.sv - sample-side and result-side signals of the thermometer encoder
interface flash_therm_enc_pipe_if #(
  parameter int N_BITS   = 5,
  parameter int ERRCNT_W = 8
);
  localparam int M = 2**N_BITS - 1;

  logic                sample_en;
  logic [M-1:0]        therm_in;
  logic                gray_sel;
  logic                clr_cnt;
  logic [N_BITS-1:0]   code_out;
  logic                valid_out;
  logic                ovr;
  logic                udr;
  logic                bubble;
  logic [ERRCNT_W-1:0] bubble_cnt;

  modport master (
    output sample_en, therm_in, gray_sel, clr_cnt,
    input  code_out, valid_out, ovr, udr, bubble, bubble_cnt
  );

  modport slave (
    input  sample_en, therm_in, gray_sel, clr_cnt,
    output code_out, valid_out, ovr, udr, bubble, bubble_cnt
  );
endinterface

// File: rtl/flash_therm_enc_pipe.sv
// rtl/flash_therm_enc_pipe.sv - pipelined thermometer-to-binary/Gray encoder with bubble correction
// Capture -> majority correct -> priority encode -> output register; latency 3 edges after capture.
module flash_therm_enc_pipe #(
  parameter int N_BITS   = 5,
  parameter int ERRCNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  flash_therm_enc_pipe_if.slave  bus
);
  localparam int M = 2**N_BITS - 1;
  localparam logic [ERRCNT_W-1:0] CNT_MAX = '1;

  logic                v1, v2, v3;
  logic [M-1:0]        t1, c2;
  logic                g1, g2, g3;
  logic                bub2, bub3;
  logic [N_BITS-1:0]   b3;
  logic [M-1:0]        c1;
  logic [N_BITS-1:0]   b2;
  logic [M+1:0]        ext;

  logic [N_BITS-1:0]   code_q;
  logic                valid_q, ovr_q, udr_q, bubble_q;
  logic [ERRCNT_W-1:0] cnt_q;

  // Virtual comparators below the lowest (always 1) and above the highest (always 0).
  assign ext = {1'b0, t1, 1'b1};

  always_comb begin
    c1 = '0;
    for (int i = 0; i < M; i++) begin
      c1[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2]) | (ext[i+1] & ext[i+2]);
    end
  end

  always_comb begin
    b2 = '0;
    for (int i = 0; i < M; i++) begin
      if (c2[i]) b2 = N_BITS'(i + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      t1   <= '0;
      g1   <= 1'b0;
      v2   <= 1'b0;
      c2   <= '0;
      g2   <= 1'b0;
      bub2 <= 1'b0;
      v3   <= 1'b0;
      b3   <= '0;
      g3   <= 1'b0;
      bub3 <= 1'b0;
    end else begin
      v1 <= bus.sample_en;
      if (bus.sample_en) begin
        t1 <= bus.therm_in;
        g1 <= bus.gray_sel;
      end
      v2   <= v1;
      c2   <= c1;
      g2   <= g1;
      bub2 <= v1 && (c1 != t1);
      v3   <= v2;
      b3   <= b2;
      g3   <= g2;
      bub3 <= bub2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      code_q   <= '0;
      ovr_q    <= 1'b0;
      udr_q    <= 1'b0;
      bubble_q <= 1'b0;
    end else begin
      valid_q <= v3;
      if (v3) begin
        code_q   <= g3 ? (b3 ^ (b3 >> 1)) : b3;
        ovr_q    <= (b3 == N_BITS'(M));
        udr_q    <= (b3 == '0);
        bubble_q <= bub3;
      end
    end
  end

  // Counts the sample presented on the outputs during the previous cycle; clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.clr_cnt) begin
      cnt_q <= '0;
    end else if (valid_q && bubble_q && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + ERRCNT_W'(1);
    end
  end

  assign bus.code_out   = code_q;
  assign bus.valid_out  = valid_q;
  assign bus.ovr        = ovr_q;
  assign bus.udr        = udr_q;
  assign bus.bubble     = bubble_q;
  assign bus.bubble_cnt = cnt_q;
endmodule

// File: doc/flash_therm_enc_pipe.md
Name: flash_therm_enc_pipe

Overview:
Parametrised, pipelined thermometer-to-binary encoder for the flash ADC back end. It succeeds the combinational thermometer decoder / priority encoder path. The comparator thermometer word is registered, bubble-corrected by 3-input majority vote, and priority-encoded. The result is output as binary or Gray code, with range flags and a saturating bubble-error counter. It sits between the comparator bank and the SoC sample interface.

Parameters:
N_BITS, 5, output code width; comparator count M = 2**N_BITS - 1 (default 31).
ERRCNT_W, 8, width of the saturating bubble-error counter.

Ports:
clk  input  1  single system clock, all state on rising edge.
rst_n  input  1  asynchronous, active-low reset.
sample_en  input  1  qualifies therm_in this cycle; no backpressure.
therm_in  input  M  comparator outputs; bit i = 1 when Vin > ref[i]; bit 0 = lowest threshold.
gray_sel  input  1  output format for this sample: 0 = binary, 1 = Gray; sampled with sample_en.
clr_cnt  input  1  synchronous clear of bubble_cnt.
code_out  output  N_BITS  encoded sample code.
valid_out  output  1  one-cycle strobe, code_out and flags valid.
ovr  output  1  code == M (all comparators high), qualified by valid_out.
udr  output  1  code == 0 (all comparators low), qualified by valid_out.
bubble  output  1  correction altered at least one bit of this sample.
bubble_cnt  output  ERRCNT_W  count of bubbled samples, saturating at all-ones.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: every register clears asynchronously, including all pipeline data and valid bits. All outputs read 0 while rst_n = 0. A reset mid-operation flushes the pipeline, and in-flight samples are dropped (no valid_out for them).
- 3-stage pipeline, fixed latency 3. sample_en high at rising edge k gives valid_out high after edge k+3. Back-to-back samples at 1 per clock are supported, and order is preserved. A sample_en gap produces an equal valid_out gap.
- S1 (capture): when sample_en = 1, register therm_in, gray_sel and the valid bit. When sample_en = 0, the valid bit clears. Data registers may hold their old values.
- S2 (bubble correct): c[i] = maj(t[i-1], t[i], t[i+1]) with virtual t[-1] = 1 and t[M] = 0. Bubble flag = (c != t). The flag is raised only on valid samples.
- S3 (encode):
  - b = index of highest set bit of c, plus 1; b = 0 if c is all zero. Width N_BITS, never exceeds M.
  - code_out = b when gray_sel = 0, else b ^ (b >> 1).
  - ovr = (b == M); udr = (b == 0). Both use the binary value regardless of format.
- Output registers (code_out, ovr, udr, bubble) update only with a valid S3 sample and hold their last value otherwise.
- bubble_cnt:
  - Increments by 1 on each cycle where valid_out = 1 and bubble = 1.
  - Holds at 2**ERRCNT_W - 1 once reached; it never wraps.
  - clr_cnt = 1 sets the counter to 0 on the next edge. Clear wins over a simultaneous increment.
- gray_sel changes between consecutive samples take effect per sample. There is no mixing within one sample.
- Corrected output is monotonic for any input with at most single-bit bubbles or sparkles. Multi-bit bubbles are encoded from the corrected word, with no further correction.

Test Plan:
1. Reset: hold rst_n = 0 with random inputs. Require code_out = 0, valid_out = 0, ovr = udr = bubble = 0, bubble_cnt = 0. Release, then drive sample_en = 0 for 5 cycles and require valid_out to stay 0.
2. Clean code, latency: therm_in = 0x0000FFFF, sample_en pulse at edge k. Require valid_out = 1 only after edge k+3, code_out = 16, bubble = 0. Repeat with gray_sel = 1 and require code_out = 24 (0x18).
3. Bubble and sparkle:
   - therm_in = 0x000000FB: require code_out = 8, bubble = 1, bubble_cnt = 1.
   - therm_in = 0x00001007: require code_out = 3, bubble = 1, bubble_cnt = 2.
4. Range: therm_in = 0x7FFFFFFF requires code_out = 31, ovr = 1, udr = 0. therm_in = 0 requires code_out = 0, udr = 1, ovr = 0.
5. Streaming: drive sample_en for 4 consecutive cycles with codes 1, 2, 3, 4, then one idle cycle, then code 5. Require valid_out pattern 1,1,1,1,0,1 and codes 1, 2, 3, 4, 5 in order. Assert reset during a later 3-sample burst and require none of those samples to appear.
6. Counter: with ERRCNT_W = 2, apply 5 bubbled samples and require bubble_cnt = 3 (saturated). Assert clr_cnt in the same cycle as a bubbled valid_out and require bubble_cnt = 0 on the next cycle.
